// File: rtl/alg_amba_vip_apb_pkg.sv
// ---------------------------------------------------------------------------
// alg_amba_vip_apb_pkg
// Shared types and constants for the APB arbiter slice.
//   apb_arb_state_e : transfer sequencing states of the arbiter
//   APB_DW          : APB data width used on every port
//   id_width()      : width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package alg_amba_vip_apb_pkg;

    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } apb_arb_state_e;

    // A single requester still needs a 1-bit index so the port is never zero-width.
    function automatic int id_width(input int n);
        return (n == 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alg_amba_vip_rr_arbiter.sv
// ---------------------------------------------------------------------------
// alg_amba_vip_rr_arbiter
// Round-robin selector with a last-grant pointer.
//   clk, rstn  : clock, asynchronous active-low reset
//   req        : request vector (already masked by the caller)
//   advance    : accept the current grant and move the pointer onto it
//   gnt        : index of the first requester after the last grant
//   gnt_valid  : at least one request is present
// The pointer resets to N-1 so that index 0 has highest priority first.
// ---------------------------------------------------------------------------
module alg_amba_vip_rr_arbiter
    import alg_amba_vip_apb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [IW-1:0] gnt,
    output logic          gnt_valid
);

    logic [IW-1:0] last;
    logic [IW-1:0] idx;
    int            cand;

    // Search last+1, last+2, ... wrapping modulo N; the first hit wins.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        idx       = '0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last) + i) % N;
            idx  = IW'(cand);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt       = idx;
            end
        end
    end

    // The pointer only moves when the caller actually commits a grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last <= IW'(N - 1);
        end else if (advance && gnt_valid) begin
            last <= gnt;
        end
    end

endmodule

// File: rtl/alg_amba_vip_apbarb.sv
// ---------------------------------------------------------------------------
// alg_amba_vip_apbarb
// N-to-1 round-robin APB arbiter; one fully registered transfer at a time.
//   clk, rstn                     : clock, asynchronous active-low reset
//   cfg_enable                    : per-requester enable mask
//   req_psel/penable/pwrite       : upstream APB control, one bit per requester
//   req_pwdata, req_paddr         : upstream write data / address, flattened
//   req_prdata/pready/pslverr     : upstream completion, one-cycle pulse
//   m_psel/penable/pwrite/pwdata/paddr : downstream APB request
//   m_prdata/pready/pslverr       : downstream APB response
//   gnt_id                        : current or last granted requester
//   busy                          : a transfer is in progress
// ---------------------------------------------------------------------------
module alg_amba_vip_apbarb
    import alg_amba_vip_apb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 22,
    localparam int ID_W = id_width(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_MASTERS-1:0]        cfg_enable,
    input  logic [NUM_MASTERS-1:0]        req_psel,
    input  logic [NUM_MASTERS-1:0]        req_penable,
    input  logic [NUM_MASTERS-1:0]        req_pwrite,
    input  logic [NUM_MASTERS*32-1:0]     req_pwdata,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] req_paddr,
    output logic [NUM_MASTERS*32-1:0]     req_prdata,
    output logic [NUM_MASTERS-1:0]        req_pready,
    output logic [NUM_MASTERS-1:0]        req_pslverr,
    output logic                          m_psel,
    output logic                          m_penable,
    output logic                          m_pwrite,
    output logic [31:0]                   m_pwdata,
    output logic [ADDR_WIDTH-1:0]         m_paddr,
    input  logic [31:0]                   m_prdata,
    input  logic                          m_pready,
    input  logic                          m_pslverr,
    output logic [ID_W-1:0]               gnt_id,
    output logic                          busy
);

    apb_arb_state_e          state;
    apb_arb_state_e          state_n;
    logic [NUM_MASTERS-1:0]  eligible;
    logic [ID_W-1:0]         rr_gnt;
    logic                    rr_valid;
    logic                    advance;
    logic                    win_write;
    logic [APB_DW-1:0]       win_wdata;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic                    penable_unused;

    // The upstream penable level is deliberately not checked.
    assign penable_unused = ^req_penable;

    assign eligible = req_psel & cfg_enable;
    assign busy     = (state != S_IDLE);

    alg_amba_vip_rr_arbiter #(
        .N (NUM_MASTERS)
    ) u_rr (
        .clk       (clk),
        .rstn      (rstn),
        .req       (eligible),
        .advance   (advance),
        .gnt       (rr_gnt),
        .gnt_valid (rr_valid)
    );

    // Mux the winning requester's request fields out of the flattened buses.
    always_comb begin
        win_write = 1'b0;
        win_wdata = '0;
        win_addr  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (rr_gnt == ID_W'(i)) begin
                win_write = req_pwrite[i];
                win_wdata = req_pwdata[i*APB_DW +: APB_DW];
                win_addr  = req_paddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; arbitration is only committed from idle.
    always_comb begin
        state_n = state;
        advance = 1'b0;
        case (state)
            S_IDLE: begin
                if (rr_valid) begin
                    advance = 1'b1;
                    state_n = S_SETUP;
                end
            end
            S_SETUP:  state_n = S_ACCESS;
            S_ACCESS: if (m_pready) state_n = S_RESP;
            S_RESP:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Registered downstream request and upstream completion. Address and
    // write data are left holding after completion; only psel/penable drop.
    // The response state clears the upstream pulse, which also gives the
    // finished requester a cycle to drop psel before the next arbitration.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_psel      <= 1'b0;
            m_penable   <= 1'b0;
            m_pwrite    <= 1'b0;
            m_pwdata    <= '0;
            m_paddr     <= '0;
            gnt_id      <= '0;
            req_pready  <= '0;
            req_pslverr <= '0;
            req_prdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rr_valid) begin
                        gnt_id    <= rr_gnt;
                        m_pwrite  <= win_write;
                        m_pwdata  <= win_wdata;
                        m_paddr   <= win_addr;
                        m_psel    <= 1'b1;
                        m_penable <= 1'b0;
                    end
                end
                S_SETUP: begin
                    m_penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (m_pready) begin
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        for (int i = 0; i < NUM_MASTERS; i++) begin
                            if (gnt_id == ID_W'(i)) begin
                                req_pready[i]                  <= 1'b1;
                                req_pslverr[i]                 <= m_pslverr;
                                req_prdata[i*APB_DW +: APB_DW] <= m_prdata;
                            end
                        end
                    end
                end
                S_RESP: begin
                    req_pready  <= '0;
                    req_pslverr <= '0;
                    req_prdata  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alg_amba_vip_apbarb.sv
// ---------------------------------------------------------------------------
// tb_alg_amba_vip_apbarb
// Self-checking bench for the round-robin APB arbiter (4 requesters).
// The expected winner comes from a priority queue that is rotated so the
// requesters after the last winner come first.
// ---------------------------------------------------------------------------
module tb_alg_amba_vip_apbarb;

    localparam int NM = 4;
    localparam int AW = 22;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NM-1:0]     cfg_enable;
    logic [NM-1:0]     req_psel;
    logic [NM-1:0]     req_penable;
    logic [NM-1:0]     req_pwrite;
    logic [NM*32-1:0]  req_pwdata;
    logic [NM*AW-1:0]  req_paddr;
    logic [NM*32-1:0]  req_prdata;
    logic [NM-1:0]     req_pready;
    logic [NM-1:0]     req_pslverr;
    logic              m_psel;
    logic              m_penable;
    logic              m_pwrite;
    logic [31:0]       m_pwdata;
    logic [AW-1:0]     m_paddr;
    logic [31:0]       m_prdata;
    logic              m_pready;
    logic              m_pslverr;
    logic [1:0]        gnt_id;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    logic              wr_v [NM];
    logic [31:0]       wd_v [NM];
    logic [AW-1:0]     ad_v [NM];

    int prio[$];

    alg_amba_vip_apbarb #(
        .NUM_MASTERS (NM),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_enable  (cfg_enable),
        .req_psel    (req_psel),
        .req_penable (req_penable),
        .req_pwrite  (req_pwrite),
        .req_pwdata  (req_pwdata),
        .req_paddr   (req_paddr),
        .req_prdata  (req_prdata),
        .req_pready  (req_pready),
        .req_pslverr (req_pslverr),
        .m_psel      (m_psel),
        .m_penable   (m_penable),
        .m_pwrite    (m_pwrite),
        .m_pwdata    (m_pwdata),
        .m_paddr     (m_paddr),
        .m_prdata    (m_prdata),
        .m_pready    (m_pready),
        .m_pslverr   (m_pslverr),
        .gnt_id      (gnt_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: priority list, winner is the first eligible entry,
    // then everything up to and including the winner moves to the back.
    function automatic void model_reset();
        prio.delete();
        for (int i = 0; i < NM; i++) prio.push_back(i);
    endfunction

    function automatic int model_pick(input logic [NM-1:0] elig);
        int w;
        w = -1;
        foreach (prio[k]) if (w < 0 && elig[prio[k]]) w = prio[k];
        return w;
    endfunction

    function automatic void model_commit(input int w);
        int h;
        if (w < 0) return;
        do begin
            h = prio.pop_front();
            prio.push_back(h);
        end while (h != w);
    endfunction

    // Drive all requesters' request fields from the per-requester tables.
    task automatic applyStimulus(input logic [NM-1:0] psel, input logic [NM-1:0] en);
        req_psel    = psel;
        req_penable = psel;
        cfg_enable  = en;
        for (int i = 0; i < NM; i++) begin
            req_pwrite[i]            = wr_v[i];
            req_pwdata[i*32 +: 32]   = wd_v[i];
            req_paddr[i*AW +: AW]    = ad_v[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
        applyStimulus('0, '1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    // Wait (bounded) for the setup phase of a downstream transfer.
    task automatic wait_setup(output bit ok);
        int guard;
        guard = 0;
        while (!(m_psel && !m_penable) && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        ok = m_psel && !m_penable;
    endtask

    // Downstream slave: answer the access phase after 'waits' wait states.
    // Returns at the negedge of the cycle carrying the upstream pulse.
    task automatic slave_respond(input int waits, input logic [31:0] rd,
                                 input logic err, output bit ok);
        int guard;
        guard = 0;
        ok = 1'b1;
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
        while (!(m_psel && m_penable) && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!(m_psel && m_penable)) begin
            ok = 1'b0;
            return;
        end
        repeat (waits) @(negedge clk);
        m_pready = 1'b1; m_prdata = rd; m_pslverr = err;
        @(negedge clk);
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
        for (int i = 0; i < NM; i++) begin
            wr_v[i] = 1'b0; wd_v[i] = '0; ad_v[i] = '0;
        end
        applyStimulus('0, '1);
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({m_psel, m_penable, m_pwrite, busy} !== 4'b0) begin
            n_err++;
            $display("[TB] FAIL reset_ctrl: got psel/pen/pwr/busy=%b want 0000", {m_psel, m_penable, m_pwrite, busy});
        end
        n_cmp++;
        if (m_paddr !== '0 || m_pwdata !== '0 || gnt_id !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_data: got paddr=%h pwdata=%h gnt=%0d want 0", m_paddr, m_pwdata, gnt_id);
        end
        n_cmp++;
        if (req_pready !== '0 || req_pslverr !== '0 || req_prdata !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_up: got pready=%b pslverr=%b prdata=%h want 0", req_pready, req_pslverr, req_prdata);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int exp;
        do_reset();
        m_pready = 1'b1;
        wr_v[0] = 1'b1; wd_v[0] = 32'hDEADBEEF; ad_v[0] = 22'h00100;
        applyStimulus(4'b0001, 4'b1111);
        exp = model_pick(4'b0001);
        model_commit(exp);
        @(negedge clk);
        n_cmp++;
        if (m_psel !== 1'b1 || m_penable !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL single_c1: got psel=%b pen=%b busy=%b want 1 0 1", m_psel, m_penable, busy);
        end
        n_cmp++;
        if (m_paddr !== 22'h00100 || m_pwdata !== 32'hDEADBEEF || m_pwrite !== 1'b1 || gnt_id !== 2'(exp)) begin
            n_err++;
            $display("[TB] FAIL single_req: got paddr=%h pwdata=%h pwrite=%b gnt=%0d want 00100 deadbeef 1 %0d",
                     m_paddr, m_pwdata, m_pwrite, gnt_id, exp);
        end
        @(negedge clk);
        n_cmp++;
        if (m_psel !== 1'b1 || m_penable !== 1'b1 || req_pready !== '0) begin
            n_err++;
            $display("[TB] FAIL single_c2: got psel=%b pen=%b pready=%b want 1 1 0000", m_psel, m_penable, req_pready);
        end
        @(negedge clk);
        n_cmp++;
        if (req_pready !== 4'b0001 || m_psel !== 1'b0 || m_penable !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_c3: got pready=%b psel=%b pen=%b want 0001 0 0", req_pready, m_psel, m_penable);
        end
        applyStimulus('0, 4'b1111);
        @(negedge clk);
        n_cmp++;
        if (req_pready !== '0 || busy !== 1'b0 || m_paddr !== 22'h00100 || m_pwdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("[TB] FAIL single_c4: got pready=%b busy=%b paddr=%h pwdata=%h want 0000 0 00100 deadbeef",
                     req_pready, busy, m_paddr, m_pwdata);
        end
        m_pready = 1'b0;
    endtask

    task automatic test_contention();
        int exp;
        bit ok;
        do_reset();
        for (int i = 0; i < NM; i++) begin
            wr_v[i] = 1'b1; wd_v[i] = 32'hA000_0000 + i; ad_v[i] = AW'(22'h01000 + 22'(i * 16));
        end
        applyStimulus(4'b1111, 4'b1111);
        m_pready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_setup(ok);
            exp = model_pick(4'b1111);
            model_commit(exp);
            n_cmp++;
            if (!ok || gnt_id !== 2'(exp) || m_paddr !== ad_v[exp]) begin
                n_err++;
                $display("[TB] FAIL contention_%0d: got ok=%b gnt=%0d paddr=%h want 1 %0d %h",
                         g, ok, gnt_id, m_paddr, exp, ad_v[exp]);
            end
            @(negedge clk);
        end
        applyStimulus('0, 4'b1111);
        repeat (4) @(negedge clk);
        m_pready = 1'b0;
    endtask

    task automatic test_wait_error();
        int exp;
        bit ok;
        wr_v[1] = 1'b0; ad_v[1] = 22'h2A5A5;
        applyStimulus(4'b0010, 4'b1111);
        m_pready = 1'b0;
        exp = model_pick(4'b0010);
        model_commit(exp);
        wait_setup(ok);
        n_cmp++;
        if (!ok || gnt_id !== 2'(exp) || m_pwrite !== 1'b0 || m_paddr !== 22'h2A5A5) begin
            n_err++;
            $display("[TB] FAIL wait_grant: got ok=%b gnt=%0d pwrite=%b paddr=%h want 1 %0d 0 2a5a5",
                     ok, gnt_id, m_pwrite, m_paddr, exp);
        end
        @(negedge clk);
        for (int w = 0; w < 4; w++) begin
            n_cmp++;
            if (m_psel !== 1'b1 || m_penable !== 1'b1 || req_pready !== '0) begin
                n_err++;
                $display("[TB] FAIL wait_hold_%0d: got psel=%b pen=%b pready=%b want 1 1 0000",
                         w, m_psel, m_penable, req_pready);
            end
            if (w == 3) begin
                m_pready = 1'b1; m_prdata = 32'h12345678; m_pslverr = 1'b1;
            end
            @(negedge clk);
        end
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
        applyStimulus('0, 4'b1111);
        n_cmp++;
        if (req_pready !== 4'b0010 || req_pslverr !== 4'b0010 || req_prdata !== {64'h0, 32'h12345678, 32'h0}) begin
            n_err++;
            $display("[TB] FAIL wait_resp: got pready=%b pslverr=%b prdata=%h want 0010 0010 ..12345678_00000000",
                     req_pready, req_pslverr, req_prdata);
        end
        @(negedge clk);
        n_cmp++;
        if (req_pready !== '0 || req_pslverr !== '0 || req_prdata !== '0) begin
            n_err++;
            $display("[TB] FAIL wait_clear: got pready=%b pslverr=%b prdata=%h want 0", req_pready, req_pslverr, req_prdata);
        end
    endtask

    task automatic test_mask();
        int exp;
        bit ok;
        do_reset();
        applyStimulus(4'b1111, 4'b1101);
        m_pready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_setup(ok);
            exp = model_pick(4'b1101);
            model_commit(exp);
            n_cmp++;
            if (!ok || gnt_id !== 2'(exp)) begin
                n_err++;
                $display("[TB] FAIL mask_%0d: got ok=%b gnt=%0d want 1 %0d", g, ok, gnt_id, exp);
            end
            @(negedge clk);
        end
        applyStimulus('0, 4'b1111);
        repeat (4) @(negedge clk);
        m_pready = 1'b0;
    endtask

    task automatic test_mask_mid();
        int exp;
        bit ok;
        do_reset();
        applyStimulus(4'b0001, 4'b1111);
        m_pready = 1'b0;
        exp = model_pick(4'b0001);
        model_commit(exp);
        wait_setup(ok);
        n_cmp++;
        if (!ok || gnt_id !== 2'(exp)) begin
            n_err++;
            $display("[TB] FAIL maskmid_grant: got ok=%b gnt=%0d want 1 %0d", ok, gnt_id, exp);
        end
        @(negedge clk);
        applyStimulus(4'b0101, 4'b1110);
        m_pready = 1'b1; m_prdata = 32'h0BADF00D;
        @(negedge clk);
        n_cmp++;
        if (req_pready !== 4'b0001 || req_prdata[31:0] !== 32'h0BADF00D) begin
            n_err++;
            $display("[TB] FAIL maskmid_done: got pready=%b prdata0=%h want 0001 0badf00d", req_pready, req_prdata[31:0]);
        end
        exp = model_pick(4'b0101 & 4'b1110);
        model_commit(exp);
        wait_setup(ok);
        n_cmp++;
        if (!ok || gnt_id !== 2'(exp)) begin
            n_err++;
            $display("[TB] FAIL maskmid_next: got ok=%b gnt=%0d want 1 %0d", ok, gnt_id, exp);
        end
        applyStimulus('0, 4'b1111);
        repeat (4) @(negedge clk);
        m_pready = 1'b0; m_prdata = '0;
    endtask

    task automatic test_reset_mid();
        int exp;
        bit ok;
        do_reset();
        applyStimulus(4'b0010, 4'b1111);
        m_pready = 1'b0;
        model_commit(model_pick(4'b0010));
        wait_setup(ok);
        @(negedge clk);
        n_cmp++;
        if (!ok || busy !== 1'b1 || m_penable !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL rstmid_access: got ok=%b busy=%b pen=%b want 1 1 1", ok, busy, m_penable);
        end
        #1 rstn = 1'b0;
        #1;
        n_cmp++;
        if (m_psel !== 1'b0 || m_penable !== 1'b0 || busy !== 1'b0 || req_pready !== '0) begin
            n_err++;
            $display("[TB] FAIL rstmid_async: got psel=%b pen=%b busy=%b pready=%b want 0 0 0 0000",
                     m_psel, m_penable, busy, req_pready);
        end
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(4'b0101, 4'b1111);
        m_pready = 1'b1;
        exp = model_pick(4'b0101);
        model_commit(exp);
        wait_setup(ok);
        n_cmp++;
        if (!ok || gnt_id !== 2'(exp) || m_paddr !== ad_v[exp]) begin
            n_err++;
            $display("[TB] FAIL rstmid_regrant: got ok=%b gnt=%0d paddr=%h want 1 %0d %h",
                     ok, gnt_id, m_paddr, exp, ad_v[exp]);
        end
        applyStimulus('0, 4'b1111);
        repeat (4) @(negedge clk);
        m_pready = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 24; it++) begin
            logic [NM-1:0]    ps;
            logic [NM-1:0]    en;
            logic [NM-1:0]    elig;
            logic [31:0]      rd;
            logic             err;
            logic [NM*32-1:0] exp_rd;
            int               exp;
            int               waits;
            bit               ok;
            for (int i = 0; i < NM; i++) begin
                wr_v[i] = 1'($urandom_range(0, 1));
                wd_v[i] = $urandom;
                ad_v[i] = AW'($urandom);
            end
            ps = NM'($urandom);
            en = NM'($urandom);
            elig = ps & en;
            applyStimulus(ps, en);
            if (elig == '0) begin
                repeat (3) @(negedge clk);
                n_cmp++;
                if (m_psel !== 1'b0 || busy !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL rand_idle_%0d: got psel=%b busy=%b want 0 0", it, m_psel, busy);
                end
                continue;
            end
            exp = model_pick(elig);
            model_commit(exp);
            wait_setup(ok);
            n_cmp++;
            if (!ok || gnt_id !== 2'(exp) || m_paddr !== ad_v[exp] || m_pwdata !== wd_v[exp] || m_pwrite !== wr_v[exp]) begin
                n_err++;
                $display("[TB] FAIL rand_grant_%0d: got ok=%b gnt=%0d paddr=%h pwdata=%h pwrite=%b want 1 %0d %h %h %b",
                         it, ok, gnt_id, m_paddr, m_pwdata, m_pwrite, exp, ad_v[exp], wd_v[exp], wr_v[exp]);
            end
            rd = $urandom;
            err = 1'($urandom_range(0, 1));
            waits = $urandom_range(0, 3);
            slave_respond(waits, rd, err, ok);
            exp_rd = '0;
            exp_rd[exp*32 +: 32] = rd;
            n_cmp++;
            if (!ok || req_pready !== NM'(1 << exp) || req_prdata !== exp_rd || req_pslverr !== (NM'(err) << exp)) begin
                n_err++;
                $display("[TB] FAIL rand_resp_%0d: got ok=%b pready=%b pslverr=%b prdata=%h want 1 %b %b %h",
                         it, ok, req_pready, req_pslverr, req_prdata, NM'(1 << exp), NM'(err) << exp, exp_rd);
            end
            applyStimulus('0, en);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wait_error();
        test_mask();
        test_mask_mid();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
